// File: rtl/dyn_branch_predictor.sv
// Dynamic branch predictor for the IF stage: PHT of saturating counters,
// tagged BTB, optional gshare history and resolved-branch statistics.
module dyn_branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int TAG_BITS   = 8,
    parameter int GHR_BITS   = 0,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  Reset_L,
    input  logic                  bp_enable,
    input  logic [31:0]           if_pc,
    output logic                  pred_taken,
    output logic [31:0]           pred_target,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic [31:0]           upd_pc,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    input  logic [31:0]           upd_target,
    input  logic                  upd_mispredict,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int GW      = (GHR_BITS > 0) ? GHR_BITS : 1;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    localparam logic [CTR_BITS-1:0] CTR_INIT =
        CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    logic [CTR_BITS-1:0]   ctr [ENTRIES];
    logic [ENTRIES-1:0]    btbValid;
    logic [TAG_BITS-1:0]   btbTag [ENTRIES];
    logic [31:0]           btbTarget [ENTRIES];
    logic [GW-1:0]         ghr;

    logic [INDEX_BITS-1:0] ghrExt;
    logic [INDEX_BITS-1:0] lookIdx;
    logic [TAG_BITS-1:0]   lookTag;
    logic [TAG_BITS-1:0]   updTag;
    logic                  btbHit;
    logic                  ctrTaken;
    logic [31:0]           pcPlus4;
    logic                  unusedBits;

    assign ghrExt  = (GHR_BITS > 0) ? INDEX_BITS'(ghr) : '0;
    assign lookIdx = if_pc[INDEX_BITS+1:2] ^ ghrExt;
    assign lookTag = if_pc[TAG_HI:TAG_LO];
    assign updTag  = upd_pc[TAG_HI:TAG_LO];

    assign btbHit   = btbValid[lookIdx] && (btbTag[lookIdx] == lookTag);
    assign ctrTaken = ctr[lookIdx][CTR_BITS-1];
    assign pcPlus4  = if_pc + 32'd4;

    // Reset gating keeps the fall-through path clean while Reset_L is low.
    assign pred_index  = lookIdx;
    assign pred_taken  = Reset_L && bp_enable && btbHit && ctrTaken;
    assign pred_target = pred_taken ? btbTarget[lookIdx] : pcPlus4;

    assign unusedBits = ^{if_pc[1:0], if_pc[31:TAG_HI+1],
                          upd_pc[TAG_LO-1:0], upd_pc[31:TAG_HI+1]};

    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= CTR_INIT;
            end
        end else if (upd_valid) begin
            if (upd_taken) begin
                if (ctr[upd_index] != CTR_MAX) begin
                    ctr[upd_index] <= ctr[upd_index] + 1'b1;
                end
            end else if (ctr[upd_index] != '0) begin
                ctr[upd_index] <= ctr[upd_index] - 1'b1;
            end
        end
    end

    // Not-taken outcomes leave the BTB alone; taken ones overwrite aliases.
    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            btbValid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                btbTag[i]    <= '0;
                btbTarget[i] <= '0;
            end
        end else if (upd_valid && upd_taken) begin
            btbValid[upd_index]  <= 1'b1;
            btbTag[upd_index]    <= updTag;
            btbTarget[upd_index] <= upd_target;
        end
    end

    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            ghr <= '0;
        end else if (upd_valid && (GHR_BITS > 0)) begin
            ghr <= GW'({ghr, upd_taken});
        end
    end

    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (upd_valid) begin
            if (stat_branches != STAT_MAX) begin
                stat_branches <= stat_branches + 1'b1;
            end
            if (upd_mispredict && (stat_mispredicts != STAT_MAX)) begin
                stat_mispredicts <= stat_mispredicts + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dyn_branch_predictor.sv
// Scoreboard bench for dyn_branch_predictor: a bimodal instance and a
// gshare instance with narrow statistics share one stimulus stream.
module tb_dyn_branch_predictor;

    logic        CLK;
    logic        Reset_L;
    logic        bp_enable;
    logic [31:0] if_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [5:0]  upd_index;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;

    logic        predTaken;
    logic [31:0] predTarget;
    logic [5:0]  predIndex;
    logic [15:0] statBr;
    logic [15:0] statMis;

    logic        gPredTaken;
    logic [31:0] gPredTarget;
    logic [5:0]  gPredIndex;
    logic [3:0]  gStatBr;
    logic [3:0]  gStatMis;

    dyn_branch_predictor dut (
        .CLK(CLK), .Reset_L(Reset_L), .bp_enable(bp_enable),
        .if_pc(if_pc), .pred_taken(predTaken),
        .pred_target(predTarget), .pred_index(predIndex),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_branches(statBr), .stat_mispredicts(statMis)
    );

    dyn_branch_predictor #(.GHR_BITS(4), .STAT_WIDTH(4)) dutG (
        .CLK(CLK), .Reset_L(Reset_L), .bp_enable(bp_enable),
        .if_pc(if_pc), .pred_taken(gPredTaken),
        .pred_target(gPredTarget), .pred_index(gPredIndex),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_branches(gStatBr), .stat_mispredicts(gStatMis)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   nCmp = 0;
    int   nBad = 0;

    int       nBr, nMis, gBr, gMis;
    logic [3:0] ghrM;

    localparam logic [31:0] P  = 32'h00400010;
    localparam logic [31:0] PA = 32'h00400110;
    localparam logic [31:0] T  = 32'h00400040;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1);
    end

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0: return {31'b0, predTaken};
            1: return predTarget;
            2: return 32'(predIndex);
            3: return 32'(statBr);
            4: return 32'(statMis);
            5: return 32'(gPredIndex);
            6: return 32'(gStatBr);
            7: return 32'(gStatMis);
            8: return {31'b0, gPredTaken};
            9: return gPredTarget;
            default: return 32'hdeadbeef;
        endcase
    endfunction

    // Monitor: outputs are stable at posedge, away from the negedge updates.
    initial begin
        chk_t c;
        logic [31:0] act;
        forever begin
            @(posedge CLK);
            while (q.size() > 0) begin
                c   = q.pop_front();
                act = actual(c.sel);
                nCmp++;
                if (act !== c.exp) begin
                    nBad++;
                    $display("FAIL %s: got %h, required %h",
                             c.name, act, c.exp);
                end
            end
        end
    end

    task automatic expectVal(input string name, input int sel,
                             input logic [31:0] v);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = v;
        q.push_back(c);
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic expStats(input string tag);
        expectVal({tag, "_br"}, 3, 32'(nBr));
        expectVal({tag, "_mis"}, 4, 32'(nMis));
        expectVal({tag, "_gbr"}, 6, 32'(gBr));
        expectVal({tag, "_gmis"}, 7, 32'(gMis));
    endtask

    task automatic doUpd(input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic mis,
                         input logic [5:0] idx);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_mispredict = mis;
        upd_index      = idx;
        @(negedge CLK);
        #1;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        if (nBr < 65535) nBr++;
        if (mis && nMis < 65535) nMis++;
        if (gBr < 15) gBr++;
        if (mis && gMis < 15) gMis++;
        ghrM = {ghrM[2:0], tk};
    endtask

    function automatic logic [5:0] gIdx(input logic [31:0] pc);
        return pc[7:2] ^ {2'b00, ghrM};
    endfunction

    function automatic logic [5:0] bIdx(input logic [31:0] pc);
        return pc[7:2];
    endfunction

    initial begin
        Reset_L = 1'b0; bp_enable = 1'b1; if_pc = P;
        upd_valid = 1'b0; upd_pc = '0; upd_index = '0;
        upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
        nBr = 0; nMis = 0; gBr = 0; gMis = 0; ghrM = '0;

        step();
        expectVal("rst_taken", 0, 32'd0);
        expectVal("rst_target", 1, 32'h00400014);
        expStats("rst");
        step();
        Reset_L = 1'b1;
        step();

        doUpd(P, 1'b1, T, 1'b1, bIdx(P));
        expectVal("tr1_taken", 0, 32'd1);
        doUpd(P, 1'b1, T, 1'b0, bIdx(P));
        expectVal("tr2_taken", 0, 32'd1);
        expectVal("tr2_target", 1, T);
        expectVal("tr2_index", 2, 32'd4);
        doUpd(P, 1'b0, T, 1'b1, bIdx(P));
        expectVal("nt1_taken", 0, 32'd1);
        doUpd(P, 1'b0, T, 1'b0, bIdx(P));
        expectVal("nt2_taken", 0, 32'd0);
        expectVal("nt2_target", 1, 32'h00400014);
        expStats("tr");
        step();

        for (int i = 0; i < 5; i++) doUpd(P, 1'b1, T, 1'b0, bIdx(P));
        expectVal("sat_hi_taken", 0, 32'd1);
        doUpd(P, 1'b0, T, 1'b0, bIdx(P));
        expectVal("sat_hi_dec", 0, 32'd1);
        for (int i = 0; i < 3; i++) doUpd(P, 1'b0, T, 1'b1, bIdx(P));
        doUpd(P, 1'b1, T, 1'b0, bIdx(P));
        expectVal("sat_lo_inc1", 0, 32'd0);
        doUpd(P, 1'b1, T, 1'b0, bIdx(P));
        expectVal("sat_lo_inc2", 0, 32'd1);
        step();

        upd_mispredict = 1'b1;
        step();
        upd_mispredict = 1'b0;
        expStats("misonly");
        step();

        if_pc = PA;
        expectVal("alias_taken", 0, 32'd0);
        expectVal("alias_target", 1, 32'h00400114);
        expectVal("alias_index", 2, 32'd4);
        step();
        if_pc = P;
        bp_enable = 1'b0;
        expectVal("dis_taken", 0, 32'd0);
        expectVal("dis_target", 1, 32'h00400014);
        step();
        bp_enable = 1'b1;
        expectVal("en_taken", 0, 32'd1);
        step();

        doUpd(PA, 1'b1, 32'h00400200, 1'b1, bIdx(PA));
        if_pc = PA;
        expectVal("ovw_taken", 0, 32'd1);
        expectVal("ovw_target", 1, 32'h00400200);
        step();
        if_pc = P;
        expectVal("ovw_old_taken", 0, 32'd0);
        step();

        if_pc = 32'h00400020;
        expectVal("same_old_taken", 0, 32'd0);
        expectVal("same_old_target", 1, 32'h00400024);
        doUpd(32'h00400020, 1'b1, 32'h00400080, 1'b0,
              bIdx(32'h00400020));
        expectVal("same_new_taken", 0, 32'd1);
        expectVal("same_new_target", 1, 32'h00400080);
        expStats("pre_arst");
        step();

        Reset_L = 1'b0;
        nBr = 0; nMis = 0; gBr = 0; gMis = 0; ghrM = '0;
        expectVal("arst_taken", 0, 32'd0);
        expectVal("arst_target", 1, 32'h00400024);
        expStats("arst");
        step();
        Reset_L = 1'b1;
        if_pc = P;
        expectVal("g_idx0", 5, 32'd4);
        step();

        doUpd(P, 1'b1, T, 1'b0, gIdx(P));
        expectVal("post_rst_upd", 0, 32'd1);
        doUpd(P, 1'b1, T, 1'b1, gIdx(P));
        doUpd(P, 1'b0, T, 1'b0, gIdx(P));
        doUpd(P, 1'b1, T, 1'b0, gIdx(P));
        expectVal("g_idx_hist", 5, 32'd9);
        expectVal("g_hist_taken", 8, 32'd0);
        expectVal("g_hist_target", 9, 32'h00400014);
        step();

        for (int i = 0; i < 6; i++)
            doUpd(P, 1'(i & 1), T, (i == 1) || (i == 4), gIdx(P));
        expStats("ten");
        step();

        for (int i = 0; i < 10; i++) doUpd(P, 1'b1, T, 1'b1, gIdx(P));
        expStats("sat_br");
        for (int i = 0; i < 4; i++) doUpd(P, 1'b0, T, 1'b1, gIdx(P));
        expStats("sat_mis");
        step();

        for (int i = 0; i < 8 && q.size() != 0; i++) @(negedge CLK);
        if (q.size() != 0) begin
            nBad++;
            $display("FAIL drain: %0d pending, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/dyn_branch_predictor.md
Name: dyn_branch_predictor

Overview:
Parametrised dynamic branch predictor that replaces the static not-taken policy of the 5-stage MIPS pipeline. It sits in IF: it looks up the fetch PC combinationally and supplies a predicted next PC. EX feeds back resolved branch outcomes to train a pattern history table (PHT) of saturating counters and a tagged branch target buffer (BTB). Optional global history (gshare) and hit/mispredict statistics counters are included.

Parameters:
INDEX_BITS, 6, log2 of PHT/BTB entries (64)
CTR_BITS, 2, saturating counter width (1..4)
TAG_BITS, 8, BTB tag width, taken from pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]
GHR_BITS, 0, global history length; 0 = bimodal, else gshare (must be <= INDEX_BITS)
STAT_WIDTH, 16, width of statistics counters

Ports:
CLK  in  1  pipeline clock; all state updates on negedge CLK
Reset_L  in  1  reset, asynchronous, active-low
bp_enable  in  1  1 = dynamic prediction; 0 = forced static not-taken
if_pc  in  32  current fetch PC
pred_taken  out  1  predicted taken
pred_target  out  32  predicted next PC
pred_index  out  INDEX_BITS  table index used for this lookup; pipeline carries it to EX
upd_valid  in  1  resolved conditional branch in EX this cycle
upd_pc  in  32  PC of resolved branch
upd_index  in  INDEX_BITS  pred_index captured at that branch's fetch
upd_taken  in  1  actual outcome
upd_target  in  32  actual taken target
upd_mispredict  in  1  EX detected a wrong prediction (direction or target)
stat_branches  out  STAT_WIDTH  resolved branch count
stat_mispredicts  out  STAT_WIDTH  mispredict count

Behaviour:
- Reset (async, Reset_L=0): all counters = 2^(CTR_BITS-1)-1 (weakly not-taken; 01 for 2-bit), all BTB valid = 0, GHR = 0, stats = 0. Outputs during reset: pred_taken=0, pred_target=if_pc+4.
- Lookup (combinational, zero latency): pred_index = if_pc[INDEX_BITS+1:2] XOR {GHR zero-extended to INDEX_BITS}; hit = BTB[pred_index].valid && tag match.
- pred_taken = bp_enable && hit && counter[pred_index] MSB. pred_target = pred_taken ? BTB target : if_pc+4 (32-bit wrap).
- Update (negedge CLK when upd_valid=1): counter[upd_index] increments if upd_taken, otherwise decrements; it saturates at 0 and 2^CTR_BITS-1 and never wraps.
- BTB on update: if upd_taken, the entry is written with valid=1, the upd_pc tag and upd_target, overwriting any alias. If not taken, the BTB is left unchanged.
- GHR (GHR_BITS>0): on update, GHR <= {GHR[GHR_BITS-2:0], upd_taken}. The GHR is non-speculative.
- Updates still occur when bp_enable=0; tables keep training.
- Same-index lookup and update in the same cycle: lookup returns pre-update contents. The new value is visible after the negedge.
- Stats: stat_branches += 1 per upd_valid. stat_mispredicts += 1 when upd_valid && upd_mispredict. Both saturate at all-ones. upd_mispredict without upd_valid is ignored.
- Tables are flop arrays with no read latency. No X may propagate from unwritten entries.
- Reset asserted mid-operation clears everything immediately. The first update after release applies normally.

Test Plan:
1. Reset, if_pc=0x00400010 -> pred_taken=0, pred_target=0x00400014, stats=0.
2. GHR_BITS=0: two updates pc=0x00400010 taken target=0x00400040 -> counter 01→10→11; lookup pred_taken=1, pred_target=0x00400040. Then two not-taken updates -> counter 01, pred_taken=0, pred_target=0x00400014.
3. Saturation: 5 taken updates -> counter stays 11. One not-taken -> 10, still predicts taken.
4. Alias: train pc=0x00400010 taken; lookup pc=0x00400110 (same index, different tag) -> hit=0, pred_taken=0, target=pc+4. bp_enable=0 on a trained PC -> pred_taken=0.
5. Same-cycle lookup and update at one index: pred_taken shows the old value before the negedge and the new value after.
6. GHR_BITS=4: updates T,T,N,T produce GHR=1101 and pred_index = pc[7:2]^6'b001101. 3 mispredicts out of 10 updates -> stat_branches=10, stat_mispredicts=3. STAT_WIDTH=4 with 20 updates saturates at 15. Asserting Reset_L low mid-stream clears all state asynchronously.
